// File: rtl/seven_segment_display_arbiter.sv
// ----------------------------------------------------------------------------
// seven_segment_display_arbiter
//
// Shares one 8-digit seven-segment display between NUM_SRC value sources and
// a single one-shot alert source. Valid sources are shown round-robin, each
// for DWELL_CYCLES clocks. A "next" pulse skips ahead early, and "freeze"
// holds the current source. An alert request preempts the rotation for
// ALERT_CYCLES clocks.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   src_val      packed source values, source i at [32*i+31:32*i]
//   src_valid    per-source eligibility
//   next         one-cycle pulse: advance to the next valid source now
//   freeze       hold the current source, dwell timer paused
//   alert_req    alert request, held until alert_ack
//   alert_val    alert value, captured when the request is accepted
//   alert_ack    one-cycle pulse: alert accepted
//   disp_val     value driven to the seven-segment controller
//   disp_src     index of the source being shown
//   disp_alert   high while the alert is shown
//   disp_strobe  one-cycle pulse alongside a new disp_src/disp_alert
// ----------------------------------------------------------------------------
module seven_segment_display_arbiter #(
   parameter int NUM_SRC      = 4,
   parameter int DWELL_CYCLES = 100_000_000,
   parameter int ALERT_CYCLES = 50_000_000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [32*NUM_SRC-1:0]      src_val,
   input  logic [NUM_SRC-1:0]         src_valid,
   input  logic                       next,
   input  logic                       freeze,
   input  logic                       alert_req,
   input  logic [31:0]                alert_val,
   output logic                       alert_ack,
   output logic [31:0]                disp_val,
   output logic [$clog2(NUM_SRC)-1:0] disp_src,
   output logic                       disp_alert,
   output logic                       disp_strobe
);

   localparam int SEL_W = $clog2(NUM_SRC);
   // Sources are padded to a power of two. The search can then wrap by plain
   // overflow of the select counter. Padded slots are never valid.
   localparam int NPAD  = 1 << SEL_W;
   localparam int DW_W  = $clog2(DWELL_CYCLES);
   localparam int AW_W  = $clog2(ALERT_CYCLES);

   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
   localparam logic [AW_W-1:0] ALERT_LAST = AW_W'(ALERT_CYCLES - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHOW  = 2'd1;
   localparam logic [1:0] ST_ALERT = 2'd2;

   logic [1:0]       state_q,  state_d;
   logic [SEL_W-1:0] sel_q,    sel_d;
   logic [DW_W-1:0]  dwell_q,  dwell_d;
   logic [AW_W-1:0]  acnt_q,   acnt_d;
   logic [31:0]      val_q,    val_d;
   logic             alert_q,  alert_d;
   logic             ack_q,    ack_d;
   logic             strobe_q, strobe_d;

   logic [31:0]      val_arr [NPAD];
   logic [NPAD-1:0]  vld_pad;
   logic [SEL_W:0]   nxt_pick;
   logic [SEL_W:0]   low_pick;
   logic             adv;

   for (genvar g = 0; g < NPAD; g++) begin : g_pad
      if (g < NUM_SRC) begin : g_src
         assign val_arr[g] = src_val[32*g +: 32];
         assign vld_pad[g] = src_valid[g];
      end else begin : g_zero
         assign val_arr[g] = '0;
         assign vld_pad[g] = 1'b0;
      end
   end

   // Searches cur+1, cur+2, ... and wraps back to cur itself last.
   // The result is {found, index}.
   function automatic logic [SEL_W:0] pick_next(input logic [SEL_W-1:0] cur,
                                                input logic [NPAD-1:0]  vld);
      logic             found;
      logic [SEL_W-1:0] idx;
      logic [SEL_W-1:0] cand;
      found = 1'b0;
      idx   = cur;
      for (int k = 1; k <= NPAD; k++) begin
         cand = cur + SEL_W'(k);
         if (!found && vld[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      dwell_d  = dwell_q;
      acnt_d   = acnt_q;
      val_d    = val_q;
      alert_d  = alert_q;
      ack_d    = 1'b0;
      adv      = 1'b0;
      nxt_pick = pick_next(sel_q, vld_pad);
      // Starting "before" slot 0 makes the search return the lowest valid index.
      low_pick = pick_next({SEL_W{1'b1}}, vld_pad);

      case (state_q)
         ST_IDLE: begin
            val_d   = '0;
            alert_d = 1'b0;
            if (alert_req) begin
               ack_d   = 1'b1;
               val_d   = alert_val;
               alert_d = 1'b1;
               acnt_d  = '0;
               state_d = ST_ALERT;
            end else if (low_pick[SEL_W]) begin
               sel_d   = low_pick[SEL_W-1:0];
               dwell_d = '0;
               val_d   = val_arr[low_pick[SEL_W-1:0]];
               state_d = ST_SHOW;
            end
         end

         ST_SHOW: begin
            val_d = val_arr[sel_q];
            if (alert_req) begin
               // The alert wins over any advance in the same cycle. The dwell
               // count is left as is, so an expiry still fires on return.
               ack_d   = 1'b1;
               val_d   = alert_val;
               alert_d = 1'b1;
               acnt_d  = '0;
               state_d = ST_ALERT;
            end else begin
               adv = !vld_pad[sel_q] ||
                     (!freeze && (next || (dwell_q == DWELL_LAST)));
               if (adv) begin
                  dwell_d = '0;
                  if (nxt_pick[SEL_W]) begin
                     sel_d = nxt_pick[SEL_W-1:0];
                     val_d = val_arr[nxt_pick[SEL_W-1:0]];
                  end else begin
                     val_d   = '0;
                     state_d = ST_IDLE;
                  end
               end else if (!freeze) begin
                  dwell_d = dwell_q + DW_W'(1);
               end
            end
         end

         ST_ALERT: begin
            if (acnt_q == ALERT_LAST) begin
               alert_d = 1'b0;
               if (|vld_pad) begin
                  // Resume the same source. If it went invalid meanwhile, the
                  // first cycle back in SHOW advances away from it.
                  val_d   = val_arr[sel_q];
                  state_d = ST_SHOW;
               end else begin
                  val_d   = '0;
                  dwell_d = '0;
                  state_d = ST_IDLE;
               end
            end else begin
               acnt_d = acnt_q + AW_W'(1);
            end
         end

         default: begin
            val_d   = '0;
            alert_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      // The strobe is registered together with the new src/alert, so it lands
      // in the first cycle of the changed display. Entry from IDLE strobes even
      // when the selected index happens to equal the previous one.
      strobe_d = (sel_d != sel_q) || (alert_d != alert_q) ||
                 ((state_q == ST_IDLE) && (state_d == ST_SHOW));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         sel_q    <= '0;
         dwell_q  <= '0;
         acnt_q   <= '0;
         val_q    <= '0;
         alert_q  <= 1'b0;
         ack_q    <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         dwell_q  <= dwell_d;
         acnt_q   <= acnt_d;
         val_q    <= val_d;
         alert_q  <= alert_d;
         ack_q    <= ack_d;
         strobe_q <= strobe_d;
      end
   end

   assign alert_ack   = ack_q;
   assign disp_val    = val_q;
   assign disp_src    = sel_q;
   assign disp_alert  = alert_q;
   assign disp_strobe = strobe_q;

endmodule
